// File: rtl/counter_cmd_sequencer.sv
// Command sequencer driving a 4-bit up/down counter: one load pulse, N run cycles, done.
// Optional 2-entry command FIFO enabled by defining CMD_QUEUE_EN.
module counter_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] cnt_in,
    output logic             cnt_sel,
    output logic             cnt_mode,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] remain;
    logic             accept;
    logic             take;
    logic [WIDTH-1:0] nxt_value;
    logic             nxt_dir;
    logic [LEN_W-1:0] nxt_len;

    assign busy   = (state != IDLE);
    assign accept = cmd_valid && cmd_ready;

`ifdef CMD_QUEUE_EN
    localparam int ENT_W = WIDTH + 1 + LEN_W;

    logic [ENT_W-1:0] fifo [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             pop;
    logic             push;

    assign cmd_ready = !reset && (count != 2'd2);
    assign take      = ((state == IDLE) || (state == DONE)) && ((count != 2'd0) || accept);
    assign pop       = take && (count != 2'd0);
    // An empty FIFO lets the incoming command bypass storage straight into LOAD.
    assign push      = accept && !(take && (count == 2'd0));
    assign {nxt_value, nxt_dir, nxt_len} = (count != 2'd0) ? fifo[rd_ptr]
                                         : {cmd_value, cmd_dir, cmd_len};

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= {cmd_value, cmd_dir, cmd_len};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
`else
    assign cmd_ready = !reset && (state == IDLE);
    assign take      = (state == IDLE) && accept;
    assign nxt_value = cmd_value;
    assign nxt_dir   = cmd_dir;
    assign nxt_len   = cmd_len;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt_in   <= '0;
            cnt_sel  <= 1'b0;
            cnt_mode <= 1'b0;
            done     <= 1'b0;
            remain   <= '0;
        end else begin
            cnt_sel <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (take) begin
                        state    <= LOAD;
                        cnt_sel  <= 1'b1;
                        cnt_in   <= nxt_value;
                        cnt_mode <= nxt_dir;
                        remain   <= nxt_len;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    if (remain == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    remain <= remain - ONE;
                    if (remain == ONE) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Scoreboard bench for counter_cmd_sequencer with a behavioural 4-bit counter model.
// Queue-specific sequences are compiled in when CMD_QUEUE_EN is defined.
module tb_counter_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_value;
    logic       cmd_dir;
    logic [7:0] cmd_len;
    logic [3:0] cnt_in;
    logic       cnt_sel;
    logic       cnt_mode;
    logic       busy;
    logic       done;

    counter_cmd_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_value(cmd_value), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
        .cnt_in(cnt_in), .cnt_sel(cnt_sel), .cnt_mode(cnt_mode),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] value;
        logic       dir;
        int         len;
        logic [3:0] fin;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       run_q[$];
    exp_t       me;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         last_done = -100;
    int         load_cyc = 0;
    int         busy_run = 0;
    int         chain_loads = 0;
    bit         chain_chk = 0;
    bit         prev_sel = 0;
    logic [3:0] model = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference up/down counter fed by the sequencer outputs.
    always @(posedge clk) begin
        if (reset)         model <= 4'd0;
        else if (cnt_sel)  model <= cnt_in;
        else if (cnt_mode) model <= model - 4'd1;
        else               model <= model + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            run_q.delete();
            busy_run = 0;
            prev_sel = 0;
        end else begin
            busy_run = busy ? busy_run + 1 : 0;
            if (cnt_sel) begin
                chk("sel_single_cycle", {31'd0, prev_sel}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("cnt_in", {28'd0, cnt_in}, {28'd0, me.value});
                    chk("cnt_mode", {31'd0, cnt_mode}, {31'd0, me.dir});
`ifdef CMD_QUEUE_EN
                    if (chain_chk) begin
                        chain_loads++;
                        if (chain_loads > 1) chk("chain_gap", cyc - last_done, 1);
                    end
`else
                    chk("idle_gap_ge2", {31'd0, (cyc - last_done) >= 2}, 1);
`endif
                    run_q.push_back(me);
                    load_cyc = cyc;
                end
            end
            if (done) begin
                n_done++;
                last_done = cyc;
                if (run_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    me = run_q.pop_front();
                    chk("done_latency", cyc - load_cyc, me.len + 1);
                    chk("counter_at_done", {28'd0, model}, {28'd0, me.fin});
`ifndef CMD_QUEUE_EN
                    chk("busy_cycles", busy_run, me.len + 2);
`endif
                end
            end
            prev_sel = cnt_sel;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] v, input logic d, input int l);
        exp_t e;
        bit   ok;
        ok        = 0;
        cmd_valid = 1'b1;
        cmd_value = v;
        cmd_dir   = d;
        cmd_len   = l[7:0];
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 1, 0);
        end else begin
`ifndef CMD_QUEUE_EN
            chk("accept_in_idle", {31'd0, busy}, 0);
`endif
            e.value = v;
            e.dir   = d;
            e.len   = l;
            e.fin   = d ? v - l[3:0] : v + l[3:0];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    int nd;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_value = 4'd0;
        cmd_dir   = 1'b0;
        cmd_len   = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, cnt_in, cnt_sel, cnt_mode, done, busy, cmd_ready}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: reset mid-stream for 3 cycles.
        send(4'd6, 1'b0, 20);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        nd = n_done;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs_1", {26'd0, cnt_in, cnt_sel, cnt_mode, done, busy, cmd_ready}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outputs_2", {26'd0, cnt_in, cnt_sel, cnt_mode, done, busy, cmd_ready}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'd0, cmd_ready}, 1);
        chk("busy_after_release", {31'd0, busy}, 0);
        @(posedge clk);
        #1;

        // Test 2: up-count, len 5.
        send(4'd9, 1'b0, 5);
        wait_idle();
        chk("hold_cnt_in", {28'd0, cnt_in}, 9);
        chk("hold_cnt_mode", {31'd0, cnt_mode}, 0);

        // Test 3: zero length, down.
        send(4'd3, 1'b1, 0);
        wait_idle();

        // Test 4: abort four cycles into RUN.
        send(4'd15, 1'b0, 10);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        nd = n_done;
        @(negedge clk);
        chk("busy_before_abort", {31'd0, busy}, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_sel_done", {30'd0, cnt_sel, done}, 0);
        chk("abort_ready", {31'd0, cmd_ready}, 1);
        repeat (15) @(posedge clk);
        chk("abort_no_done", n_done - nd, 0);
        #1;

        // Test 5: back-to-back commands held on the interface.
        nd = n_done;
        send(4'd5, 1'b0, 2);
        send(4'd7, 1'b1, 2);
        wait_idle();
        chk("two_done_pulses", n_done - nd, 2);

        // Maximum run length, wrapping counter model.
        send(4'd0, 1'b1, 255);
        wait_idle();

`ifdef CMD_QUEUE_EN
        // Test 6: queued commands chain with no idle cycles.
        nd        = n_done;
        chain_chk = 1;
        send(4'd1, 1'b0, 1);
        send(4'd2, 1'b1, 1);
        send(4'd4, 1'b0, 1);
        send(4'd8, 1'b0, 1);
        wait_idle();
        chain_chk = 0;
        chk("queue_done_pulses", n_done - nd, 4);
        chk("queue_chained_loads", chain_loads, 4);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size() + run_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
